// File: rtl/block_pkg.sv
// block_pkg: shared block type, packer FSM states and buffer sizing helpers
package block_pkg;
  localparam int BLOCK_W = 64;
  typedef logic [BLOCK_W-1:0] block_t;
  typedef enum logic {FILL, FLUSH} state_t;
  function automatic int cap_of(input int in_blocks, input int out_blocks);
    return out_blocks + in_blocks - 1;
  endfunction
  function automatic int cnt_w_of(input int in_blocks, input int out_blocks);
    return $clog2(out_blocks + in_blocks);
  endfunction
endpackage

// File: rtl/block_shift_buffer.sv
// block_shift_buffer: CAP-block fifo-like array that drops from the head and appends at the fill point
module block_shift_buffer
  import block_pkg::*;
#(
  parameter int BLOCK_SIZE = 64,
  parameter int IN_BLOCKS = 2,
  parameter int OUT_BLOCKS = 4,
  parameter int CAP = cap_of(IN_BLOCKS, OUT_BLOCKS),
  parameter int CW = cnt_w_of(IN_BLOCKS, OUT_BLOCKS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CW-1:0]                    shift,
  input  logic [IN_BLOCKS*BLOCK_SIZE-1:0]  app_data,
  input  logic [CW-1:0]                    app_num,
  output logic [OUT_BLOCKS*BLOCK_SIZE-1:0] head,
  output logic [CW-1:0]                    cnt
);
  logic [CAP*BLOCK_SIZE-1:0] blocks_q, blocks_d;
  logic [CW-1:0] base;
  // slots at or above cnt are kept zero, so the head needs no masking
  always_comb begin
    base = cnt - shift;
    blocks_d = blocks_q >> (int'(shift) * BLOCK_SIZE);
    for (int j = 0; j < IN_BLOCKS; j++)
      if (j < int'(app_num)) blocks_d[(int'(base) + j)*BLOCK_SIZE +: BLOCK_SIZE] = app_data[j*BLOCK_SIZE +: BLOCK_SIZE];
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      blocks_q <= '0;
      cnt <= '0;
    end else begin
      blocks_q <= blocks_d;
      cnt <= cnt - shift + app_num;
    end
  assign head = blocks_q[OUT_BLOCKS*BLOCK_SIZE-1:0];
endmodule

// File: rtl/block_packer.sv
// block_packer: repacks variable-count block beats into dense OUT_BLOCKS-wide words, draining on last
module block_packer
  import block_pkg::*;
#(
  parameter int BLOCK_SIZE = 64,
  parameter int IN_BLOCKS = 2,
  parameter int OUT_BLOCKS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IN_BLOCKS*BLOCK_SIZE-1:0]  in_data,
  input  logic [31:0]                      in_num,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [OUT_BLOCKS*BLOCK_SIZE-1:0] out_data,
  output logic [31:0]                      out_num,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             out_ready
);
  localparam int CAP = cap_of(IN_BLOCKS, OUT_BLOCKS);
  localparam int CW = cnt_w_of(IN_BLOCKS, OUT_BLOCKS);
  localparam logic [CW-1:0] OB = CW'(OUT_BLOCKS);
  state_t state;
  logic [CW-1:0] cnt, emit_n, shift, app_num, n;
  logic [OUT_BLOCKS*BLOCK_SIZE-1:0] head;
  logic slot_free, emit, acc, last_word;
  always_comb begin
    slot_free = !out_valid || out_ready;
    emit = slot_free && (cnt >= OB || state == FLUSH);
    emit_n = cnt >= OB ? OB : cnt;
    last_word = state == FLUSH && cnt <= OB;
    in_ready = state == FILL && ((cnt - (emit ? OB : '0)) < OB);
    acc = in_valid && in_ready;
    n = in_num > 32'(IN_BLOCKS) ? CW'(IN_BLOCKS) : in_num[CW-1:0];
    app_num = acc ? n : '0;
    shift = emit ? emit_n : '0;
  end
  block_shift_buffer #(
    .BLOCK_SIZE(BLOCK_SIZE), .IN_BLOCKS(IN_BLOCKS), .OUT_BLOCKS(OUT_BLOCKS), .CAP(CAP), .CW(CW)
  ) u_buf (
    .clk(clk), .rst_n(rst_n), .shift(shift), .app_data(in_data), .app_num(app_num), .head(head), .cnt(cnt)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= FILL;
      out_data <= '0;
      out_num <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (emit) begin
        out_data <= head;
        out_num <= 32'(emit_n);
        out_last <= last_word;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      state <= (emit && last_word) ? FILL : (acc && in_last) ? FLUSH : state;
    end
  always_ff @(posedge clk)
    if (rst_n && acc) assert (in_num <= 32'(IN_BLOCKS)) else $warning("in_num %0d saturated to %0d", in_num, IN_BLOCKS);
endmodule
